// File: rtl/branch_predictor_btb_if.sv
// Fetch/decode side bundle of the branch predictor.
// The pipeline is the master; the predictor is the slave.
interface branch_predictor_btb_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] pc_IF;
    logic            pred_taken_IF;
    logic [XLEN-1:0] pred_target_IF;
    logic            stall_FD;
    logic            flush_FD;
    logic            valid_ID;
    logic [XLEN-1:0] pc_ID;
    logic            is_branch_ID;
    logic            taken_ID;
    logic [XLEN-1:0] target_ID;
    logic            redirect_ID;
    logic [XLEN-1:0] redirect_pc_ID;
    logic [31:0]     branch_cnt;
    logic [31:0]     mispredict_cnt;

    modport master (
        output pc_IF, stall_FD, flush_FD, valid_ID, pc_ID,
        output is_branch_ID, taken_ID, target_ID,
        input  pred_taken_IF, pred_target_IF,
        input  redirect_ID, redirect_pc_ID,
        input  branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_IF, stall_FD, flush_FD, valid_ID, pc_ID,
        input  is_branch_ID, taken_ID, target_ID,
        output pred_taken_IF, pred_target_IF,
        output redirect_ID, redirect_pc_ID,
        output branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating counters, IF-stage lookup,
// ID-stage mispredict detection and training, plus statistics.
module branch_predictor_btb #(
    parameter int XLEN       = 32,
    parameter int ENTRIES    = 16,
    parameter int CNT_W      = 2,
    parameter bit PREDICT_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    branch_predictor_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CTR_WNT = CTR_WT - CNT_W'(1);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [CNT_W-1:0]   r_ctr    [ENTRIES];

    logic               r_pred_taken;
    logic [XLEN-1:0]    r_pred_target;
    logic [31:0]        r_branch_cnt;
    logic [31:0]        r_mispredict_cnt;

    logic [IDX_W-1:0]   w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;
    logic               w_pred_taken;
    logic [XLEN-1:0]    w_if_pc4;
    logic [XLEN-1:0]    w_pred_target;

    logic [IDX_W-1:0]   w_id_idx;
    logic [TAG_W-1:0]   w_id_tag;
    logic               w_id_hit;
    logic [XLEN-1:0]    w_id_pc4;
    logic [XLEN-1:0]    w_actual;
    logic [XLEN-1:0]    w_predicted;
    logic               w_redirect;
    logic               w_accept;
    logic               w_train_br;
    logic               w_train_inv;
    logic [CNT_W-1:0]   w_ctr_cur;
    logic [CNT_W-1:0]   w_ctr_nxt;
    logic               w_unused;

    assign w_unused = ^{bus.pc_IF[1:0], bus.pc_ID[1:0]};

    assign w_if_idx      = bus.pc_IF[IDX_W+1:2];
    assign w_if_tag      = bus.pc_IF[XLEN-1:IDX_W+2];
    assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken  = PREDICT_EN && w_if_hit && r_ctr[w_if_idx][CNT_W-1];
    assign w_if_pc4      = bus.pc_IF + PC_STEP;
    assign w_pred_target = w_pred_taken ? r_target[w_if_idx] : w_if_pc4;

    assign bus.pred_taken_IF  = w_pred_taken;
    assign bus.pred_target_IF = w_pred_target;

    assign w_id_idx    = bus.pc_ID[IDX_W+1:2];
    assign w_id_tag    = bus.pc_ID[XLEN-1:IDX_W+2];
    assign w_id_hit    = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);
    assign w_id_pc4    = bus.pc_ID + PC_STEP;
    assign w_actual    = (bus.is_branch_ID && bus.taken_ID) ? bus.target_ID : w_id_pc4;
    assign w_predicted = r_pred_taken ? r_pred_target : w_id_pc4;
    // Full-address compare: right direction with a stale target still redirects.
    assign w_redirect  = bus.valid_ID && (w_actual != w_predicted);

    assign bus.redirect_ID    = w_redirect;
    assign bus.redirect_pc_ID = w_actual;

    assign w_accept    = bus.valid_ID && !bus.stall_FD;
    assign w_train_br  = PREDICT_EN && w_accept && bus.is_branch_ID;
    assign w_train_inv = PREDICT_EN && w_accept && !bus.is_branch_ID && w_id_hit;

    assign bus.branch_cnt     = r_branch_cnt;
    assign bus.mispredict_cnt = r_mispredict_cnt;

    // Saturating counter step for the entry being trained.
    always_comb begin
        w_ctr_cur = r_ctr[w_id_idx];
        w_ctr_nxt = w_ctr_cur;
        if (bus.taken_ID) begin
            if (w_ctr_cur != {CNT_W{1'b1}}) w_ctr_nxt = w_ctr_cur + CNT_W'(1);
        end else begin
            if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - CNT_W'(1);
        end
    end

    // IF/ID-aligned prediction register; flush beats stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (bus.flush_FD) begin
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
        end else if (!bus.stall_FD) begin
            r_pred_taken  <= w_pred_taken;
            r_pred_target <= w_pred_target;
        end
    end

    // Entry valid bits: allocate on branch, drop on non-branch alias.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (w_train_br) begin
            r_valid[w_id_idx] <= 1'b1;
        end else if (w_train_inv) begin
            r_valid[w_id_idx] <= 1'b0;
        end
    end

    // Entry payload: allocate on miss, update counter/target on hit.
    always_ff @(posedge clk) begin
        if (rst && w_train_br) begin
            if (!w_id_hit) begin
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= bus.target_ID;
                r_ctr[w_id_idx]    <= bus.taken_ID ? CTR_WT : CTR_WNT;
            end else begin
                r_ctr[w_id_idx] <= w_ctr_nxt;
                if (bus.taken_ID) r_target[w_id_idx] <= bus.target_ID;
            end
        end
    end

    // Statistics counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_accept && bus.is_branch_ID) r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_accept && w_redirect) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: predictor on (u0)
// and predictor disabled (u1) fed identical stimulus.
module tb_branch_predictor_btb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_IF = 32'h100;
    logic        stall_FD = 1'b0;
    logic        flush_FD = 1'b0;
    logic        valid_ID = 1'b0;
    logic [31:0] pc_ID = 32'h0;
    logic        is_branch_ID = 1'b0;
    logic        taken_ID = 1'b0;
    logic [31:0] target_ID = 32'h0;

    int n_total = 0;
    int n_bad   = 0;

    branch_predictor_btb_if #(.XLEN(32)) b0 ();
    branch_predictor_btb_if #(.XLEN(32)) b1 ();

    assign b0.pc_IF = pc_IF;        assign b1.pc_IF = pc_IF;
    assign b0.stall_FD = stall_FD;  assign b1.stall_FD = stall_FD;
    assign b0.flush_FD = flush_FD;  assign b1.flush_FD = flush_FD;
    assign b0.valid_ID = valid_ID;  assign b1.valid_ID = valid_ID;
    assign b0.pc_ID = pc_ID;        assign b1.pc_ID = pc_ID;
    assign b0.is_branch_ID = is_branch_ID;
    assign b1.is_branch_ID = is_branch_ID;
    assign b0.taken_ID = taken_ID;  assign b1.taken_ID = taken_ID;
    assign b0.target_ID = target_ID;
    assign b1.target_ID = target_ID;

    branch_predictor_btb #(
        .XLEN(32), .ENTRIES(16), .CNT_W(2), .PREDICT_EN(1'b1)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave)
    );

    branch_predictor_btb #(
        .XLEN(32), .ENTRIES(16), .CNT_W(2), .PREDICT_EN(1'b0)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc,
                       input logic br, input logic tk,
                       input logic [31:0] tgt);
        valid_ID     = v;
        pc_ID        = pc;
        is_branch_ID = br;
        taken_ID     = tk;
        target_ID    = tgt;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        pc_IF = 32'h100;
        tick();
        tick();
        chk("rst_ptaken", {31'd0, b0.pred_taken_IF}, 32'd0);
        chk("rst_ptgt", b0.pred_target_IF, 32'h104);
        chk("rst_bcnt", b0.branch_cnt, 32'd0);
        chk("rst_mcnt", b0.mispredict_cnt, 32'd0);
        rst = 1'b1;
        tick();

        // Cold taken branch; same-cycle lookup sees pre-write contents
        drv(1, 32'h100, 1, 1, 32'h80);
        #1;
        chk("cold_redir", {31'd0, b0.redirect_ID}, 32'd1);
        chk("cold_rpc", b0.redirect_pc_ID, 32'h80);
        chk("cold_samecyc", {31'd0, b0.pred_taken_IF}, 32'd0);
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("cold_bcnt", b0.branch_cnt, 32'd1);
        chk("cold_mcnt", b0.mispredict_cnt, 32'd1);
        chk("cold_ptaken", {31'd0, b0.pred_taken_IF}, 32'd1);
        chk("cold_ptgt", b0.pred_target_IF, 32'h80);
        chk("dis_cold_pt", {31'd0, b1.pred_taken_IF}, 32'd0);
        tick();

        // Hysteresis: ctr 2 -> 1 (not taken)
        drv(1, 32'h100, 1, 0, 32'h80);
        #1;
        chk("nt_redir", {31'd0, b0.redirect_ID}, 32'd1);
        chk("nt_rpc", b0.redirect_pc_ID, 32'h104);
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("nt_ptaken", {31'd0, b0.pred_taken_IF}, 32'd0);
        chk("nt_ptgt", b0.pred_target_IF, 32'h104);
        tick();

        // Taken x3: ctr 1 -> 2 -> 3 -> 3
        drv(1, 32'h100, 1, 1, 32'h80);
        tick();
        tick();
        #1;
        chk("t3_match_redir", {31'd0, b0.redirect_ID}, 32'd0);
        tick();
        chk("t3_bcnt", b0.branch_cnt, 32'd5);
        chk("t3_mcnt", b0.mispredict_cnt, 32'd4);

        // One not-taken from saturated 3 still predicts taken
        drv(1, 32'h100, 1, 0, 32'h80);
        #1;
        chk("sat_redir", {31'd0, b0.redirect_ID}, 32'd1);
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("sat_ptaken", {31'd0, b0.pred_taken_IF}, 32'd1);
        chk("sat_mcnt", b0.mispredict_cnt, 32'd5);

        // Aliasing: 0x140 shares index 0 with 0x100
        pc_IF = 32'h140;
        #1;
        chk("alias_ptaken", {31'd0, b0.pred_taken_IF}, 32'd0);
        chk("alias_ptgt", b0.pred_target_IF, 32'h144);
        tick();
        drv(1, 32'h140, 1, 1, 32'h300);
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("alias_new_pt", {31'd0, b0.pred_taken_IF}, 32'd1);
        chk("alias_new_tgt", b0.pred_target_IF, 32'h300);
        pc_IF = 32'h100;
        #1;
        chk("alias_old_pt", {31'd0, b0.pred_taken_IF}, 32'd0);

        // Stall with a branch in ID: trains once, on release
        pc_IF = 32'h188;
        tick();
        stall_FD = 1'b1;
        drv(1, 32'h188, 1, 1, 32'h40);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_bcnt", b0.branch_cnt, 32'd7);
        chk("stall_redir", {31'd0, b0.redirect_ID}, 32'd1);
        stall_FD = 1'b0;
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("rel_bcnt", b0.branch_cnt, 32'd8);
        chk("rel_mcnt", b0.mispredict_cnt, 32'd7);
        chk("rel_ptgt", b0.pred_target_IF, 32'h40);

        // Stall holds pred_r; flush+stall clears it
        tick();
        stall_FD = 1'b1;
        tick();
        drv(1, 32'h188, 0, 0, 32'h0);
        #1;
        chk("hold_redir", {31'd0, b0.redirect_ID}, 32'd1);
        chk("hold_rpc", b0.redirect_pc_ID, 32'h18c);
        flush_FD = 1'b1;
        tick();
        flush_FD = 1'b0;
        #1;
        chk("flush_redir", {31'd0, b0.redirect_ID}, 32'd0);
        stall_FD = 1'b0;

        // Non-branch hit invalidates the entry
        pc_IF = 32'h100;
        drv(1, 32'h100, 1, 1, 32'h200);
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("nb_pre_tgt", b0.pred_target_IF, 32'h200);
        tick();
        drv(1, 32'h100, 0, 0, 32'h0);
        #1;
        chk("nb_redir", {31'd0, b0.redirect_ID}, 32'd1);
        chk("nb_rpc", b0.redirect_pc_ID, 32'h104);
        chk("dis_nb_redir", {31'd0, b1.redirect_ID}, 32'd0);
        tick();
        drv(0, 32'h0, 0, 0, 32'h0);
        #1;
        chk("nb_inval_pt", {31'd0, b0.pred_taken_IF}, 32'd0);
        chk("nb_bcnt", b0.branch_cnt, 32'd9);
        chk("nb_mcnt", b0.mispredict_cnt, 32'd9);
        chk("dis_bcnt", b1.branch_cnt, 32'd9);
        chk("dis_mcnt", b1.mispredict_cnt, 32'd7);

        // Mid-operation reset clears table and counters
        pc_IF = 32'h188;
        #1;
        chk("pre_rst_pt", {31'd0, b0.pred_taken_IF}, 32'd1);
        rst = 1'b0;
        tick();
        chk("mrst_pt", {31'd0, b0.pred_taken_IF}, 32'd0);
        chk("mrst_ptgt", b0.pred_target_IF, 32'h18c);
        chk("mrst_bcnt", b0.branch_cnt, 32'd0);
        chk("mrst_mcnt", b0.mispredict_cnt, 32'd0);
        chk("mrst_redir", {31'd0, b0.redirect_ID}, 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_pt", {31'd0, b0.pred_taken_IF}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
